// File: rtl/breakout_pkg.sv
// breakout_pkg: shared geometry constants, FSM states and overlap helper for the Breakout datapath
package breakout_pkg;
  localparam int NUM_BLOCKS = 12;
  localparam logic [9:0] BLOCK_WIDTH = 10'd80;
  localparam logic [9:0] BLOCK_HEIGHT = 10'd30;
  localparam logic [9:0] BLOCK_SPACING = 10'd40;
  localparam logic [9:0] BLOCK_PITCH = BLOCK_SPACING + BLOCK_WIDTH;
  localparam logic [9:0] ROW0_Y = 10'd40;
  localparam logic [9:0] ROW1_Y = 10'd90;
  localparam logic [9:0] ROW2_Y = 10'd140;
  localparam logic [9:0] BALL_SIZE = 10'd7;
  localparam logic [9:0] BALL_REST_Y = 10'd433;
  localparam logic [9:0] BALL_SEAT_X = 10'd46;
  localparam logic [9:0] PADDLE_X_OFF = 10'd1;
  localparam logic [9:0] PADDLE_SPAN = 10'd98;
  localparam logic [9:0] PADDLE_Y = 10'd441;
  localparam logic [9:0] PADDLE_H = 10'd8;
  localparam logic [9:0] PADDLE_MAX = 10'd540;
  localparam logic [9:0] SCREEN_H = 10'd480;
  localparam logic [9:0] X_MAX = 10'd632;
  typedef enum logic [2:0] {S_SERVE, S_PLAY, S_MOVE, S_SCAN, S_RESOLVE, S_LOST, S_WON} state_t;
  // ball box vs inclusive rectangle [x0, x0+w] x [y0, y0+h], widened so the sums cannot wrap
  function automatic logic overlap(input logic [9:0] bx, by, x0, y0, w, h);
    return {1'b0, bx} <= {1'b0, x0} + {1'b0, w} && {1'b0, bx} + {1'b0, BALL_SIZE} >= {1'b0, x0} &&
           {1'b0, by} <= {1'b0, y0} + {1'b0, h} && {1'b0, by} + {1'b0, BALL_SIZE} >= {1'b0, y0};
  endfunction
endpackage

// File: rtl/breakout_block_geom.sv
// breakout_block_geom: brick index to top-left (x, y) of that brick
module breakout_block_geom
  import breakout_pkg::*;
(
  input  logic [3:0] idx,
  output logic [9:0] x,
  output logic [9:0] y
);
  logic [2:0] col;
  // two full rows of five, then a short row using columns 1 and 3
  always_comb begin
    col = idx < 4'd5 ? idx[2:0] : idx < 4'd10 ? 3'(idx - 4'd5) : idx == 4'd10 ? 3'd1 : 3'd3;
    x = BLOCK_SPACING + BLOCK_PITCH * {7'd0, col};
    y = idx < 4'd5 ? ROW0_Y : idx < 4'd10 ? ROW1_Y : ROW2_Y;
  end
endmodule

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: once-per-frame paddle/ball/brick sequencer driving the VGA renderer
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int BALL_STEP   = 2,
  parameter int PADDLE_STEP = 4,
  parameter int START_LIVES = 3
) (
  input  logic       CLK_25MH,
  input  logic       reset,
  input  logic [9:0] hor_count,
  input  logic [9:0] ver_count,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_launch,
  output logic [9:0] paddle_pos,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       erase_enable,
  output logic [5:0] erase_pos,
  output logic [1:0] lives,
  output logic [3:0] score,
  output logic       game_over,
  output logic       game_won
);
  localparam logic [9:0] BSTEP = 10'(BALL_STEP);
  localparam logic [9:0] PSTEP = 10'(PADDLE_STEP);
  localparam logic [3:0] LAST_IDX = 4'(NUM_BLOCKS - 1);
  state_t state, state_nxt;
  logic tick, dx, dy, cx, cy, hit, bk_ov, pd_ov, miss, xwall, last_life, last_brick;
  logic [9:0] nx, ny, nx_c, ny_c, p_nxt, bk_x, bk_y;
  logic [3:0] idx, hit_idx;
  logic [11:0] alive;

  breakout_block_geom u_geom (.idx(idx), .x(bk_x), .y(bk_y));

  // frame tick, paddle step, candidate ball position and resolve decisions
  always_comb begin
    tick = hor_count == 10'd0 && ver_count == SCREEN_H;
    p_nxt = btn_left == btn_right ? paddle_pos :
            btn_left ? (paddle_pos < PSTEP ? 10'd0 : paddle_pos - PSTEP) :
            (paddle_pos > PADDLE_MAX - PSTEP ? PADDLE_MAX : paddle_pos + PSTEP);
    nx_c = dx ? ball_x + BSTEP : (ball_x < BSTEP ? 10'd0 : ball_x - BSTEP);
    ny_c = dy ? ball_y + BSTEP : (ball_y < BSTEP ? 10'd0 : ball_y - BSTEP);
    bk_ov = overlap(nx, ny, bk_x, bk_y, BLOCK_WIDTH, BLOCK_HEIGHT);
    pd_ov = dy && overlap(nx, ny, paddle_pos + PADDLE_X_OFF, PADDLE_Y, PADDLE_SPAN, PADDLE_H);
    miss = ny >= SCREEN_H;
    xwall = nx > X_MAX;
    last_life = lives == 2'd1;
    last_brick = score == LAST_IDX;
  end

  // next-state logic of the frame sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      S_SERVE:   state_nxt = tick && btn_launch ? S_PLAY : S_SERVE;
      S_PLAY:    state_nxt = tick ? S_MOVE : S_PLAY;
      S_MOVE:    state_nxt = S_SCAN;
      S_SCAN:    state_nxt = idx == LAST_IDX ? S_RESOLVE : S_SCAN;
      S_RESOLVE: state_nxt = miss ? (last_life ? S_LOST : S_SERVE) : hit && last_brick ? S_WON : S_PLAY;
      default:   state_nxt = state;
    endcase
  end

  // state register
  always_ff @(posedge CLK_25MH)
    if (reset) state <= S_SERVE;
    else state <= state_nxt;

  // game datapath: dx/dy high means moving right/down; LOST and WON leave everything untouched
  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      paddle_pos <= 10'd270;
      ball_x <= 10'd316;
      ball_y <= BALL_REST_Y;
      dx <= 1'b1;
      dy <= 1'b0;
      nx <= '0;
      ny <= '0;
      cx <= 1'b0;
      cy <= 1'b0;
      idx <= '0;
      hit <= 1'b0;
      hit_idx <= '0;
      alive <= '1;
      lives <= 2'(START_LIVES);
      score <= '0;
      erase_enable <= 1'b0;
      erase_pos <= '0;
      game_over <= 1'b0;
      game_won <= 1'b0;
    end else begin
      erase_enable <= 1'b0;
      case (state)
        S_SERVE: if (tick) begin
          paddle_pos <= p_nxt;
          ball_x <= p_nxt + BALL_SEAT_X;
          ball_y <= BALL_REST_Y;
          if (btn_launch) begin
            dx <= 1'b1;
            dy <= 1'b0;
          end
        end
        S_MOVE: begin
          paddle_pos <= p_nxt;
          nx <= nx_c;
          ny <= ny_c;
          cx <= !dx && ball_x < BSTEP;
          cy <= !dy && ball_y < BSTEP;
          idx <= '0;
          hit <= 1'b0;
        end
        S_SCAN: begin
          idx <= idx + 4'd1;
          if (!hit && alive[idx] && bk_ov) begin
            hit <= 1'b1;
            hit_idx <= idx;
          end
        end
        S_RESOLVE: if (miss) begin
          lives <= lives - 2'd1;
          game_over <= last_life;
        end else begin
          ball_x <= xwall ? X_MAX : nx;
          dx <= dx ^ (xwall | cx);
          if (hit) begin
            dy <= !dy;
            alive[hit_idx] <= 1'b0;
            erase_enable <= 1'b1;
            erase_pos <= {2'b00, hit_idx};
            score <= score + 4'd1;
            game_won <= last_brick;
          end else if (pd_ov) begin
            ball_y <= BALL_REST_Y;
            dy <= 1'b0;
          end else begin
            ball_y <= ny;
            dy <= dy ^ cy;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
